packet_arbiter: RTL and testbench

//  Round-robin arbiter that shares one FIFO write port between Inputs packet

---
 rtl/packet_arbiter_if.sv | 35 +++
 rtl/packet_arbiter.sv | 169 ++++++++++++++++
 tb/tb_packet_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/packet_arbiter_if.sv
// Framing bus between the packet sources, the arbiter and the FIFO write port.
// slave is the arbiter's view; master is the view of whatever drives it.
interface packet_arbiter_if #(
  parameter int Width      = 16,
  parameter int Inputs     = 4,
  parameter int FifoLength = 1024
);
  localparam int NumW = $clog2(FifoLength);

  logic [NumW-1:0]         ipFifoNumItems;
  logic [Inputs-1:0]       ipInput_SoP;
  logic [Inputs-1:0]       ipInput_EoP;
  logic [Inputs*Width-1:0] ipInput_Data;
  logic [Inputs-1:0]       ipInput_Valid;
  logic [Inputs-1:0]       opInput_Ready;
  logic                    opOutput_SoP;
  logic                    opOutput_EoP;
  logic [Width-1:0]        opOutput_Data;
  logic                    opOutput_Valid;
  logic [Inputs-1:0]       opGrant;
  logic                    opError;
  logic [15:0]             opDropCount;

  modport slave (
    input  ipFifoNumItems, ipInput_SoP, ipInput_EoP, ipInput_Data, ipInput_Valid,
    output opInput_Ready, opOutput_SoP, opOutput_EoP, opOutput_Data, opOutput_Valid,
    output opGrant, opError, opDropCount
  );

  modport master (
    output ipFifoNumItems, ipInput_SoP, ipInput_EoP, ipInput_Data, ipInput_Valid,
    input  opInput_Ready, opOutput_SoP, opOutput_EoP, opOutput_Data, opOutput_Valid,
    input  opGrant, opError, opDropCount
  );
endinterface

// File: rtl/packet_arbiter.sv
// Round-robin whole-packet arbiter sharing one FIFO write port between inputs.
// A grant is only issued when the FIFO can absorb a maximum-size packet.
//
// state  | meaning
// IDLE   | no owner; stray non-SoP beats are dropped, next requester is picked
// PACKET | owner's beats are forwarded until EoP or MaxPacket beats
module packet_arbiter #(
  parameter int Width      = 16,
  parameter int Inputs     = 4,
  parameter int FifoLength = 1024,
  parameter int MaxPacket  = 256
) (
  input logic             ipClk,
  input logic             ipReset,
  packet_arbiter_if.slave bus
);
  localparam int NumW  = $clog2(FifoLength);
  localparam int IdxW  = $clog2(Inputs);
  localparam int BeatW = $clog2(MaxPacket + 1);
  localparam int DropW = $clog2(Inputs + 1);

  // +2 covers the output register and the FIFO's count lag
  localparam logic [NumW:0]      Reserve  = (NumW + 1)'(MaxPacket + 2);
  localparam logic [NumW:0]      Limit    = (NumW + 1)'(FifoLength);
  localparam logic [BeatW-1:0]   MaxBeats = BeatW'(MaxPacket);

  typedef enum logic {IDLE, PACKET} state_t;

  state_t            state_q, state_d;
  logic [IdxW-1:0]   last_q, last_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [Inputs-1:0] grant_q, grant_d;
  logic [BeatW-1:0]  beats_q, beats_d;
  logic              out_sop_q, out_sop_d;
  logic              out_eop_q, out_eop_d;
  logic [Width-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              error_q, error_d;
  logic [15:0]       drop_q, drop_d;

  logic              room;
  logic [Inputs-1:0] request;
  logic [Inputs-1:0] junk;
  logic [DropW-1:0]  junk_cnt;
  logic [16:0]       drop_sum;
  logic              found;
  logic [IdxW-1:0]   pick;
  int                idx;
  logic              sel_valid;
  logic              sel_sop;
  logic              sel_eop;
  logic [Width-1:0]  sel_data;

  assign room    = ({1'b0, bus.ipFifoNumItems} + Reserve) < Limit;
  assign request = bus.ipInput_Valid & bus.ipInput_SoP;
  assign junk    = bus.ipInput_Valid & ~bus.ipInput_SoP;

  assign sel_valid = bus.ipInput_Valid[owner_q];
  assign sel_sop   = bus.ipInput_SoP[owner_q];
  assign sel_eop   = bus.ipInput_EoP[owner_q];
  assign sel_data  = bus.ipInput_Data[owner_q*Width +: Width];

  assign bus.opInput_Ready = (state_q == PACKET) ? grant_q : junk;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 1; k <= Inputs; k++) begin
      idx = (int'(last_q) + k) % Inputs;
      if (!found && request[idx]) begin
        found = 1'b1;
        pick  = IdxW'(idx);
      end
    end
  end

  always_comb begin
    junk_cnt = '0;
    for (int i = 0; i < Inputs; i++) begin
      junk_cnt = junk_cnt + DropW'(junk[i]);
    end
    drop_sum = {1'b0, drop_q} + 17'(junk_cnt);
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    beats_d     = beats_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    error_d     = 1'b0;
    drop_d      = drop_q;
    case (state_q)
      IDLE: begin
        drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        if (found && room) begin
          state_d       = PACKET;
          owner_d       = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          beats_d       = '0;
        end
      end
      PACKET: begin
        if (sel_valid) begin
          out_valid_d = 1'b1;
          out_sop_d   = sel_sop;
          out_eop_d   = sel_eop;
          out_data_d  = sel_data;
          beats_d     = beats_q + 1'b1;
          if (sel_sop && beats_q != '0) error_d = 1'b1;
          // an oversize packet is cut here; its tail is dropped later in IDLE
          if (sel_eop || beats_d == MaxBeats) begin
            if (!sel_eop) begin
              out_eop_d = 1'b1;
              error_d   = 1'b1;
            end
            state_d = IDLE;
            last_d  = owner_q;
            grant_d = '0;
            beats_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      state_q     <= IDLE;
      last_q      <= IdxW'(Inputs - 1);
      owner_q     <= '0;
      grant_q     <= '0;
      beats_q     <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      error_q     <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      beats_q     <= beats_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      error_q     <= error_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.opOutput_SoP   = out_sop_q;
  assign bus.opOutput_EoP   = out_eop_q;
  assign bus.opOutput_Data  = out_data_q;
  assign bus.opOutput_Valid = out_valid_q;
  assign bus.opGrant        = grant_q;
  assign bus.opError        = error_q;
  assign bus.opDropCount    = drop_q;
endmodule

// File: tb/tb_packet_arbiter.sv
// Scoreboard bench for packet_arbiter: packets carry their input id in the top
// data nibble, so each output beat is matched against that input's queue.
module tb_packet_arbiter;
  localparam int Width      = 16;
  localparam int Inputs     = 4;
  localparam int FifoLength = 1024;
  localparam int MaxPacket  = 256;

  typedef struct packed {
    logic             sop;
    logic             eop;
    logic [Width-1:0] data;
  } beat_t;

  typedef struct {
    int                cyc;
    int                id;
    logic              sop;
    logic              eop;
    logic [Width-1:0]  data;
    logic [Inputs-1:0] grant;
  } rec_t;

  logic ipClk   = 1'b0;
  logic ipReset = 1'b0;
  always #5 ipClk = ~ipClk;

  packet_arbiter_if #(.Width(Width), .Inputs(Inputs), .FifoLength(FifoLength)) bus ();

  packet_arbiter #(.Width(Width), .Inputs(Inputs), .FifoLength(FifoLength),
                   .MaxPacket(MaxPacket)) dut (
    .ipClk  (ipClk),
    .ipReset(ipReset),
    .bus    (bus)
  );

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  beat_t src_q[Inputs][$];
  beat_t exp_q[Inputs][$];
  int    seq[Inputs];
  int    exp_drop = 0;
  int    exp_err  = 0;
  int    err_seen = 0;
  bit    bubbles  = 0;
  bit    rand_fifo = 0;
  rec_t  log_q[$];

  always @(posedge ipClk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic bit busy();
    for (int k = 0; k < Inputs; k++)
      if (src_q[k].size() != 0 || exp_q[k].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: a packet with SoP forwards its first MaxPacket beats (the last
  // one closed with EoP and an error if no EoP came by then); everything else
  // from a non-owner in IDLE is dropped.
  task automatic push_pkt(int k, int len, bit with_sop, bit with_eop, int sop_mid);
    beat_t b;
    beat_t e;
    int    fwd;
    fwd = with_sop ? ((len > MaxPacket) ? MaxPacket : len) : 0;
    for (int j = 0; j < len; j++) begin
      b.sop  = (with_sop && j == 0) || (j == sop_mid);
      b.eop  = with_eop && (j == len - 1);
      b.data = {4'(k), 12'(seq[k])};
      seq[k]++;
      src_q[k].push_back(b);
      if (j < fwd) begin
        e = b;
        if (j > 0 && b.sop) exp_err++;
        if (j == MaxPacket - 1 && !b.eop) begin
          e.eop = 1'b1;
          exp_err++;
        end
        exp_q[k].push_back(e);
      end else begin
        exp_drop++;
      end
    end
  endtask

  task automatic drain(string name);
    int n;
    n = 0;
    while (n < 20000 && busy()) begin
      @(posedge ipClk);
      n++;
    end
    check(name, {31'd0, busy()}, 32'd0);
    repeat (4) @(posedge ipClk);
  endtask

  task automatic assert_reset();
    @(posedge ipClk);
    #3;
    ipReset = 1'b1;
    for (int k = 0; k < Inputs; k++) begin
      src_q[k].delete();
      exp_q[k].delete();
    end
    bus.ipInput_Valid = '0;
    bus.ipInput_SoP   = '0;
    bus.ipInput_EoP   = '0;
    exp_drop = 0;
    exp_err  = 0;
    err_seen = 0;
    log_q.delete();
  endtask

  task automatic release_reset();
    repeat (2) @(negedge ipClk);
    ipReset = 1'b0;
  endtask

  // driver: present each queue head, pop it once the arbiter accepted it
  initial begin
    logic [Inputs-1:0] acc;
    forever begin
      @(negedge ipClk);
      acc = bus.ipInput_Valid & bus.opInput_Ready & {Inputs{~ipReset}};
      @(posedge ipClk);
      #1;
      for (int k = 0; k < Inputs; k++) begin
        if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        if (src_q[k].size() > 0 && !(bubbles && $urandom_range(3) == 0)) begin
          bus.ipInput_Valid[k] = 1'b1;
          bus.ipInput_SoP[k]   = src_q[k][0].sop;
          bus.ipInput_EoP[k]   = src_q[k][0].eop;
          bus.ipInput_Data[k*Width +: Width] = src_q[k][0].data;
        end else begin
          bus.ipInput_Valid[k] = 1'b0;
        end
      end
      if (rand_fifo)
        bus.ipFifoNumItems = ($urandom_range(9) < 7) ? 10'($urandom_range(700))
                                                     : 10'($urandom_range(1023, 766));
    end
  end

  // monitor: pop and compare whenever the FIFO side sees a valid beat
  initial begin
    int    owner;
    int    id;
    beat_t e;
    rec_t  r;
    owner = -1;
    forever begin
      @(negedge ipClk);
      if (ipReset) begin
        owner = -1;
        continue;
      end
      if (bus.opError) err_seen++;
      if (bus.opOutput_Valid) begin
        id      = int'(bus.opOutput_Data[15:12]);
        r.cyc   = cyc;
        r.id    = id;
        r.sop   = bus.opOutput_SoP;
        r.eop   = bus.opOutput_EoP;
        r.data  = bus.opOutput_Data;
        r.grant = bus.opGrant;
        log_q.push_back(r);
        if (owner < 0) owner = id;
        check("contiguous", id, owner);
        if (exp_q[id].size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %0h want none", bus.opOutput_Data);
        end else begin
          e = exp_q[id].pop_front();
          check("beat", {14'd0, bus.opOutput_SoP, bus.opOutput_EoP, bus.opOutput_Data},
                {14'd0, e.sop, e.eop, e.data});
        end
        if (bus.opOutput_EoP) owner = -1;
      end
    end
  end

  initial begin
    int t0;
    int n;
    int sops[$];
    int eop_cyc;
    bus.ipInput_Valid  = '0;
    bus.ipInput_SoP    = '0;
    bus.ipInput_EoP    = '0;
    bus.ipInput_Data   = '0;
    bus.ipFifoNumItems = '0;
    for (int k = 0; k < Inputs; k++) seq[k] = 0;

    #1 ipReset = 1'b1;
    #1;
    check("rst_grant", 32'(bus.opGrant), 0);
    check("rst_out", {28'd0, bus.opOutput_Valid, bus.opOutput_SoP, bus.opOutput_EoP, bus.opError}, 0);
    check("rst_data", 32'(bus.opOutput_Data), 0);
    check("rst_drop", 32'(bus.opDropCount), 0);
    @(negedge ipClk);
    ipReset = 1'b0;

    // single 4-beat packet on input 0: beats at request+2 .. +5
    @(negedge ipClk);
    seq[0] = 1;
    push_pkt(0, 4, 1, 1, -1);
    t0 = cyc + 1;
    drain("t1_drain");
    check("t1_nbeats", log_q.size(), 4);
    for (int j = 0; j < log_q.size() && j < 4; j++) begin
      check("t1_cycle", log_q[j].cyc, t0 + 2 + j);
      check("t1_data", 32'(log_q[j].data), j + 1);
    end
    if (log_q.size() == 4) begin
      check("t1_grant_first", 32'(log_q[0].grant), 1);
      check("t1_grant_end", 32'(log_q[3].grant), 0);
    end

    // all inputs request at once: 0,1,2,3,0,1,2,3 with one idle cycle between
    assert_reset();
    release_reset();
    @(negedge ipClk);
    for (int k = 0; k < Inputs; k++) begin
      push_pkt(k, 3, 1, 1, -1);
      push_pkt(k, 3, 1, 1, -1);
    end
    drain("t2_drain");
    sops.delete();
    eop_cyc = -100;
    foreach (log_q[j]) begin
      if (log_q[j].sop) begin
        sops.push_back(log_q[j].id);
        if (eop_cyc >= 0) check("t2_gap", log_q[j].cyc, eop_cyc + 2);
      end
      if (log_q[j].eop) eop_cyc = log_q[j].cyc;
    end
    check("t2_npkts", sops.size(), 8);
    for (int j = 0; j < sops.size() && j < 8; j++) check("t2_order", sops[j], j % Inputs);

    // room boundary: 767 and 766 block, 765 grants on the next cycle
    assert_reset();
    release_reset();
    @(negedge ipClk);
    bus.ipFifoNumItems = 10'd767;
    push_pkt(1, 2, 1, 1, -1);
    repeat (4) begin
      @(negedge ipClk);
      check("t3_no_grant_767", 32'(bus.opGrant), 0);
      check("t3_no_ready", 32'(bus.opInput_Ready), 0);
    end
    bus.ipFifoNumItems = 10'd766;
    repeat (3) begin
      @(negedge ipClk);
      check("t3_no_grant_766", 32'(bus.opGrant), 0);
    end
    bus.ipFifoNumItems = 10'd765;
    @(negedge ipClk);
    check("t3_grant_765", 32'(bus.opGrant), 32'b0010);
    bus.ipFifoNumItems = '0;
    drain("t3_drain");

    // exact-max packet passes clean; 300 beats without EoP is cut at 256
    assert_reset();
    release_reset();
    @(negedge ipClk);
    push_pkt(2, MaxPacket, 1, 1, -1);
    push_pkt(2, 300, 1, 0, -1);
    drain("t4_drain");
    check("t4_errors", err_seen, 1);
    check("t4_drop", 32'(bus.opDropCount), 44);
    check("t4_nbeats", log_q.size(), 2 * MaxPacket);

    // stray beats without SoP are swallowed
    assert_reset();
    release_reset();
    @(negedge ipClk);
    push_pkt(1, 3, 0, 0, -1);
    drain("t5_drain");
    check("t5_drop", 32'(bus.opDropCount), 3);
    check("t5_nbeats", log_q.size(), 0);

    // reset in the middle of a packet
    assert_reset();
    release_reset();
    @(negedge ipClk);
    bus.ipFifoNumItems = '0;
    push_pkt(2, 8, 1, 1, -1);
    n = 0;
    while (n < 100 && log_q.size() < 2) begin
      @(negedge ipClk);
      n++;
    end
    check("t6_reached_beat2", {31'd0, log_q.size() >= 2}, 1);
    assert_reset();
    #1;
    check("t6_grant", 32'(bus.opGrant), 0);
    check("t6_out", {28'd0, bus.opOutput_Valid, bus.opOutput_SoP, bus.opOutput_EoP, bus.opError}, 0);
    check("t6_data", 32'(bus.opOutput_Data), 0);
    release_reset();
    @(negedge ipClk);
    push_pkt(3, 2, 1, 1, -1);
    push_pkt(0, 2, 1, 1, -1);
    drain("t6_drain");
    check("t6_nbeats", log_q.size(), 4);
    if (log_q.size() > 0) check("t6_first_owner", log_q[0].id, 0);

    // random traffic: bubbles, random FIFO fill, strays and mid-packet SoP
    assert_reset();
    release_reset();
    bubbles   = 1;
    rand_fifo = 1;
    for (int it = 0; it < 150; it++) begin
      int k;
      int kind;
      @(negedge ipClk);
      k    = $urandom_range(Inputs - 1);
      kind = $urandom_range(9);
      if (src_q[k].size() < 30) begin
        if (kind == 0)      push_pkt(k, $urandom_range(3, 1), 0, 0, -1);
        else if (kind == 1) push_pkt(k, 5, 1, 1, $urandom_range(4, 1));
        else                push_pkt(k, $urandom_range(12, 1), 1, 1, -1);
      end
      repeat ($urandom_range(3)) @(negedge ipClk);
    end
    drain("rand_drain");
    @(negedge ipClk);
    rand_fifo = 0;
    bus.ipFifoNumItems = '0;
    drain("rand_drain2");
    check("rand_drop", 32'(bus.opDropCount), exp_drop);
    check("rand_errors", err_seen, exp_err);
    bubbles = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
